// File: rtl/arm_mem_arbiter.sv
// Two-port arbiter in front of one single-port synchronous RAM: round-robin with an optional
// bounded lock, and 1-cycle read return routed to the port that issued the read.
module arm_mem_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  localparam int unsigned RW = CW + 1;

  typedef enum logic [0:0] {StRr, StLocked} state_e;

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;     // 1: port 1 wins the next contested cycle
  logic          lock_own_q, lock_own_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rv_valid_q, rv_valid_d;
  logic          rv_owner_q, rv_owner_d;
  logic [DW-1:0] hold0_q, hold1_q;

  logic          owner_req;
  logic          gnt_any;
  logic          sel_we;
  logic          sel_lock;
  logic [RW-1:0] run;

  // Grant decode
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    owner_req = lock_own_q ? m1_req : m0_req;
    if (state_q == StLocked && owner_req) begin
      m0_gnt = ~lock_own_q;
      m1_gnt = lock_own_q;
    end else if (m0_req && m1_req) begin
      m0_gnt = ~rr_ptr_q;
      m1_gnt = rr_ptr_q;
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  assign gnt_any  = m0_gnt | m1_gnt;
  assign sel_we   = m1_gnt ? m1_we : m0_we;
  assign sel_lock = m1_gnt ? m1_lock : m0_lock;

  always_comb begin
    mem_en    = gnt_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
  end

  // Next state: any grant hands priority to the other port; a lock survives only while the
  // owner keeps asking for it and its run of consecutive grants stays under LOCK_MAX.
  always_comb begin
    state_d    = StRr;
    rr_ptr_d   = rr_ptr_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = '0;
    rv_valid_d = gnt_any & ~sel_we;
    rv_owner_d = gnt_any ? m1_gnt : rv_owner_q;
    run        = RW'(1);
    if (state_q == StLocked && lock_own_q == m1_gnt) begin
      run = {1'b0, lock_cnt_q} + RW'(1);
    end
    if (gnt_any) begin
      rr_ptr_d = m0_gnt;
      if (sel_lock && run < RW'(LOCK_MAX)) begin
        state_d    = StLocked;
        lock_own_d = m1_gnt;
        lock_cnt_d = run[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRr;
      rr_ptr_q   <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
      rv_valid_q <= 1'b0;
      rv_owner_q <= 1'b0;
      hold0_q    <= '0;
      hold1_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      rv_valid_q <= rv_valid_d;
      rv_owner_q <= rv_owner_d;
      if (m0_rvalid) hold0_q <= mem_rdata;
      if (m1_rvalid) hold1_q <= mem_rdata;
    end
  end

  // Return data passes straight from the RAM output register on the valid cycle
  assign m0_rvalid = rv_valid_q & ~rv_owner_q;
  assign m1_rvalid = rv_valid_q & rv_owner_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : hold0_q;
  assign m1_rdata  = m1_rvalid ? mem_rdata : hold1_q;

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Bench for arm_mem_arbiter: per-port transaction queues drive the DUT, a transaction-level
// model of arbitration and memory contents predicts every output each cycle.
module tb_arm_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LOCK_MAX = 8;

  typedef struct packed {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk, reset;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  arm_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, zeroed on first edge
  logic [DW-1:0] ram [1 << AW];
  bit ram_init = 0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
      ram_init = 1;
    end
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state
  txn_t          q0[$], q1[$];
  txn_t          cur0, cur1;
  logic [DW-1:0] shadow [1 << AW];
  int            m_ptr, m_lock_on, m_lock_own, m_lock_n;
  bit            pend_v;
  int            pend_p;
  logic [DW-1:0] pend_d;
  logic [DW-1:0] hold [2];
  int            g;
  logic [111:0]  exp_v, obs_v;

  function automatic txn_t mk(logic we, logic lock, int addr, logic [DW-1:0] wd);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = AW'(addr); t.wdata = wd;
    return t;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_lock_on = 0; m_lock_own = 0; m_lock_n = 0;
    pend_v = 0; pend_p = 0; pend_d = '0;
    hold[0] = '0; hold[1] = '0;
    q0.delete(); q1.delete();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  // Drive the queue heads, predict this cycle's outputs, sample on the falling edge.
  task automatic drive_and_eval();
    bit r0, r1;
    txn_t t;
    logic ewe, rv0, rv1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd, rd0, rd1;
    r0 = q0.size() > 0;
    r1 = q1.size() > 0;
    cur0 = r0 ? q0[0] : '0;
    cur1 = r1 ? q1[0] : '0;
    m0_req = r0; m0_we = cur0.we; m0_lock = cur0.lock; m0_addr = cur0.addr; m0_wdata = cur0.wdata;
    m1_req = r1; m1_we = cur1.we; m1_lock = cur1.lock; m1_addr = cur1.addr; m1_wdata = cur1.wdata;
    if (m_lock_on != 0 && ((m_lock_own == 0) ? r0 : r1)) g = m_lock_own;
    else if (r0 && r1) g = m_ptr;
    else if (r0) g = 0;
    else if (r1) g = 1;
    else g = -1;
    t = (g == 1) ? cur1 : cur0;
    ewe = (g >= 0) && t.we;
    ea  = (g >= 0) ? t.addr : '0;
    ewd = (g >= 0) ? t.wdata : '0;
    rv0 = pend_v && pend_p == 0;
    rv1 = pend_v && pend_p == 1;
    rd0 = rv0 ? pend_d : hold[0];
    rd1 = rv1 ? pend_d : hold[1];
    exp_v = {g == 0, g == 1, g >= 0, ewe, ea, ewd, rv0, rv1, rd0, rd1};
    @(negedge clk);
    obs_v = {m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata,
             m0_rvalid, m1_rvalid, m0_rdata, m1_rdata};
  endtask

  // Clock edge: commit the predicted transfer to the model.
  task automatic advance();
    txn_t t;
    int run;
    @(posedge clk);
    if (pend_v) hold[pend_p] = pend_d;
    pend_v = 0;
    if (g >= 0) begin
      t = (g == 1) ? cur1 : cur0;
      if (t.we) shadow[t.addr] = t.wdata;
      else begin
        pend_v = 1; pend_p = g; pend_d = shadow[t.addr];
      end
      run = (m_lock_on != 0 && m_lock_own == g) ? m_lock_n + 1 : 1;
      m_ptr = 1 - g;
      if (t.lock && run < LOCK_MAX) begin
        m_lock_on = 1; m_lock_own = g; m_lock_n = run;
      end else begin
        m_lock_on = 0; m_lock_n = 0;
      end
      if (g == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end else begin
      m_lock_on = 0; m_lock_n = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h/%h want all zero",
               {m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_port0_rw();
    do_reset();
    q0.push_back(mk(1'b1, 1'b0, 0, 32'h0000_000A));
    q0.push_back(mk(1'b0, 1'b0, 0, '0));
    for (int i = 0; i < 4; i++) begin
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL port0_rw cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i == 2) begin
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'h0000_000A}) begin
          errors++;
          $display("FAIL port0_readback: got rv=%b%b data=%h want rv=10 data=0000000a",
                   m0_rvalid, m1_rvalid, m0_rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_alternate();
    q0.push_back(mk(1'b1, 1'b0, 4, 32'h4444_0004));
    q1.push_back(mk(1'b1, 1'b0, 8, 32'h8888_0008));
    for (int i = 0; i < 3; i++) begin
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL alt_preload cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      advance();
    end
    do_reset();
    for (int k = 0; k < 8; k++) begin
      q0.push_back(mk(1'b0, 1'b0, 4, '0));
      q1.push_back(mk(1'b0, 1'b0, 8, '0));
    end
    for (int i = 0; i < 17; i++) begin
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL alternate cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i < 16) begin
        checks++;
        if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL alt_order cyc %0d: got gnt=%b%b want port %0d", i, m0_gnt, m1_gnt, i % 2);
        end
      end
      advance();
    end
  endtask

  task automatic test_lock_max();
    for (int k = 0; k < 12; k++) q1.push_back(mk(1'b1, 1'b1, 32 + k, 32'hA000_0000 + k));
    for (int i = 0; i < 32; i++) begin
      if (i == 1) for (int k = 0; k < 20; k++) q0.push_back(mk(1'b0, 1'b0, 32 + (k % 12), '0));
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL lock_max cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i <= 8) begin
        checks++;
        if ({m0_gnt, m1_gnt} !== ((i < 8) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL lock_bound cyc %0d: got gnt=%b%b want port %0d",
                   i, m0_gnt, m1_gnt, (i < 8) ? 1 : 0);
        end
      end
      advance();
    end
  endtask

  task automatic test_early_release();
    do_reset();
    q0.push_back(mk(1'b1, 1'b1, 48, 32'hC0DE_0001));
    q0.push_back(mk(1'b1, 1'b1, 49, 32'hC0DE_0002));
    q0.push_back(mk(1'b1, 1'b0, 50, 32'hC0DE_0003));
    for (int k = 0; k < 4; k++) q1.push_back(mk(1'b0, 1'b0, 48 + k, '0));
    for (int i = 0; i < 9; i++) begin
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL early_release cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i <= 3) begin
        checks++;
        if ({m0_gnt, m1_gnt} !== ((i < 3) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL release_order cyc %0d: got gnt=%b%b want port %0d",
                   i, m0_gnt, m1_gnt, (i < 3) ? 0 : 1);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && $urandom_range(9) < 6)
        q0.push_back(mk(1'($urandom), ($urandom_range(9) < 4), $urandom_range(15), $urandom));
      if (q1.size() == 0 && $urandom_range(9) < 6)
        q1.push_back(mk(1'($urandom), ($urandom_range(9) < 4), $urandom_range(15), $urandom));
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    q1.push_back(mk(1'b1, 1'b0, 60, 32'h5A5A_1234));
    q0.push_back(mk(1'b0, 1'b1, 60, '0));
    for (int i = 0; i < 2; i++) begin
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL mid_setup cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      advance();
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_rvalid: got rv=%b%b data=%h want 00/0", m0_rvalid, m1_rvalid, m0_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL mid_after cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      advance();
    end
    q0.push_back(mk(1'b0, 1'b0, 60, '0));
    q1.push_back(mk(1'b0, 1'b0, 60, '0));
    for (int i = 0; i < 3; i++) begin
      drive_and_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL mid_contest cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i == 0) begin
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
          errors++; $display("FAIL mid_rr_ptr: got gnt=%b%b want 10", m0_gnt, m1_gnt);
        end
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    model_reset();
    g = -1;
    test_reset();
    test_port0_rw();
    test_alternate();
    test_lock_max();
    test_early_release();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
